// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO pointer logic.
//   - FIFO_ADDR_W : default FIFO address width (depth 2**FIFO_ADDR_W)
//   - bin2gray    : binary -> reflected Gray code
//   - gray2bin    : reflected Gray code -> binary
//   The functions work on a 32-bit word.  A narrower pointer is zero-extended
//   on the way in and truncated on the way out.  Leading zeros do not change
//   the low bits of either conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// -----------------------------------------------------------------------------
// sync_nff
//   STAGES-deep flop chain that brings a multi-bit Gray-coded bus into the
//   local clock domain.  Only one bit of the bus may change at a time.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset; clears every stage to 0
//     d     - asynchronous input bus (WIDTH bits)
//     q     - output of the last stage (WIDTH bits)
// -----------------------------------------------------------------------------
module sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/rd_empty_ctrl.sv
// -----------------------------------------------------------------------------
// rd_empty_ctrl
//   Read-side pointer and empty/almost-empty control for an asynchronous FIFO.
//   The write pointer (Gray) is synchronized into rd_clk.  It is compared with
//   the next read pointer, so a read and a new write in the same cycle both
//   show up in that cycle's flags.
//   Optional feature: define RD_LEVEL_EN to add the registered rd_level port.
//   Ports:
//     rd_clk       - read-domain clock
//     rst_n        - asynchronous active-low reset
//     rd_req       - consumer read request
//     wr_ptr_gray  - write pointer, Gray, asynchronous (ADDR_W+1 bits)
//     rd_en        - qualified RAM read strobe (rd_req & ~empty)
//     rd_addr      - RAM read address (ADDR_W bits)
//     rd_ptr_gray  - registered Gray read pointer to the write domain
//     empty        - registered empty flag
//     almost_empty - registered, high when level <= AE_THRESH
//     underflow    - one-cycle pulse per rejected read request
//     rd_level     - registered occupancy (RD_LEVEL_EN only)
// -----------------------------------------------------------------------------
module rd_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic              underflow
`ifdef RD_LEVEL_EN
    ,
    output logic [ADDR_W:0]   rd_level
`endif
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0] wq_last;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] level;

    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .d     (wr_ptr_gray),
        .q     (wq_last)
    );

    assign rd_en   = rd_req & ~empty;
    assign rd_addr = rbin[ADDR_W-1:0];

    // Flags look at the post-read pointer, so the read that drains the FIFO
    // raises empty on the same edge and blocks a second read.
    always_comb begin
        rbin_next = rbin + PW'(rd_en);
        gray_next = PW'(bin2gray(32'(rbin_next)));
        wbin      = PW'(gray2bin(32'(wq_last)));
        level     = wbin - rbin_next;
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin         <= '0;
            rd_ptr_gray  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rd_ptr_gray  <= gray_next;
            empty        <= (gray_next == wq_last);
            almost_empty <= (level <= AE_LVL);
            underflow    <= rd_req & empty;
        end
    end

`ifdef RD_LEVEL_EN
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_level <= '0;
        end else begin
            rd_level <= level;
        end
    end
`endif

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rd_empty_ctrl
//   Self-checking bench for rd_empty_ctrl.  The bench acts as the writer and
//   keeps plain read/write counts as its reference.  The synchronizer is
//   modelled as a queue that delays the write count by SYNC_STAGES edges.
//   Define RD_LEVEL_EN for both bench and RTL to also check rd_level.
// -----------------------------------------------------------------------------
module tb_rd_empty_ctrl;

    localparam int AW    = 4;
    localparam int S     = 2;
    localparam int T     = 2;
    localparam int MOD   = 1 << (AW + 1);
    localparam int DEPTH = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW:0]   wr_ptr_gray = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic          underflow;
`ifdef RD_LEVEL_EN
    logic [AW:0]   rd_level;
`endif

    rd_empty_ctrl #(
        .ADDR_W      (AW),
        .SYNC_STAGES (S),
        .AE_THRESH   (T)
    ) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_ptr_gray  (rd_ptr_gray),
        .empty        (empty),
        .almost_empty (almost_empty),
        .underflow    (underflow)
`ifdef RD_LEVEL_EN
        ,
        .rd_level     (rd_level)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: free-running counts and the delayed write view.
    int wcnt, rcnt;
    int wq[$];
    int m_empty, m_ae, m_uf, m_level;
    int n_rden, n_uf;
    logic [AW:0] prev_g;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wcnt = 0; rcnt = 0;
        wq.delete();
        for (int i = 0; i < S; i++) wq.push_back(0);
        m_empty = 1; m_ae = 1; m_uf = 0; m_level = 0;
        prev_g = '0;
    endtask

    task automatic check_outputs();
        chk("empty",        int'(empty),        m_empty);
        chk("almost_empty", int'(almost_empty), m_ae);
        chk("underflow",    int'(underflow),    m_uf);
        chk("rd_ptr_gray",  int'(rd_ptr_gray),  gray(rcnt % MOD));
        chk("rd_addr",      int'(rd_addr),      rcnt % DEPTH);
`ifdef RD_LEVEL_EN
        chk("rd_level",     int'(rd_level),     m_level);
`endif
    endtask

    // One rd_clk cycle, entered and left just after a falling edge.
    task automatic step(input bit req, input bit wr);
        int ws, rd, uf, rmod;
        rd_req = req;
        if (wr) begin
            wcnt++;
            wr_ptr_gray = (AW+1)'(gray(wcnt % MOD));
        end
        #1;
        chk("rd_en", int'(rd_en), int'(req) & (m_empty == 0 ? 1 : 0));
        if (rd_en) n_rden++;
        @(posedge rd_clk);
        rd = (req && m_empty == 0) ? 1 : 0;
        uf = (req && m_empty == 1) ? 1 : 0;
        ws = wq.pop_front();
        wq.push_back(wcnt % MOD);
        rcnt += rd;
        rmod    = rcnt % MOD;
        m_empty = (rmod == ws) ? 1 : 0;
        m_level = (ws - rmod + MOD) % MOD;
        m_ae    = (m_level <= T) ? 1 : 0;
        m_uf    = uf;
        @(negedge rd_clk);
        #1;
        check_outputs();
        if (underflow) n_uf++;
        if (rd) chk("gray_one_bit", $countones(rd_ptr_gray ^ prev_g), 1);
        prev_g = rd_ptr_gray;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_req = 1'b1;
        wr_ptr_gray = '0;
        #1;
        chk("rst_empty",  int'(empty), 1);
        chk("rst_ae",     int'(almost_empty), 1);
        chk("rst_gray",   int'(rd_ptr_gray), 0);
        chk("rst_addr",   int'(rd_addr), 0);
        chk("rst_rd_en",  int'(rd_en), 0);
        chk("rst_uf",     int'(underflow), 0);
`ifdef RD_LEVEL_EN
        chk("rst_level",  int'(rd_level), 0);
`endif
        @(posedge rd_clk);
        @(negedge rd_clk);
        rd_req = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge rd_clk);
        do_reset();

        // Three writes, then idle: empty lags each write by SYNC_STAGES edges.
        step(0, 1);
        chk("lit_empty_w1", int'(empty), 1);
        step(0, 1);
        chk("lit_empty_w2", int'(empty), 1);
        step(0, 1);
        chk("lit_empty_w3", int'(empty), 0);
        chk("lit_ae_w3",    int'(almost_empty), 1);
        step(0, 0);
        step(0, 0);
        chk("lit_ae_lvl3",  int'(almost_empty), 0);
`ifdef RD_LEVEL_EN
        chk("lit_level3",   int'(rd_level), 3);
`endif

        // Drain with four requests: three reads and one underflow.
        n_rden = 0; n_uf = 0;
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 0);
        chk("lit_drain_reads", n_rden, 3);
        chk("lit_drain_uf",    n_uf, 1);
        chk("lit_drain_empty", int'(empty), 1);
        chk("lit_drain_addr",  int'(rd_addr), 3);

        // Level 1, then read on the edge where a new write arrives.
        step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        chk("lit_simul_empty", int'(empty), 0);
`ifdef RD_LEVEL_EN
        chk("lit_simul_level", int'(rd_level), 1);
`endif

        // Build up to level 5, then reset between edges.
        for (int i = 0; i < 4; i++) step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("lit_level5_ae", int'(almost_empty), 0);
`ifdef RD_LEVEL_EN
        chk("lit_level5", int'(rd_level), 5);
`endif
        #2;
        do_reset();

        // Forty write/read pairs to wrap the pointer past 31.
        for (int i = 0; i < 40; i++) step(1, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("lit_wrap_rcnt", rcnt, 40);

        // Random traffic without overfilling the FIFO.
        for (int i = 0; i < 800; i++) begin
            bit r, w;
            r = ($urandom_range(0, 99) < 50);
            w = ($urandom_range(0, 99) < 50) && (wcnt - rcnt < DEPTH);
            step(r, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rd_empty_ctrl.md
RD_EMPTY_CTRL -- requirements
Module: rd_empty_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, giving the FIFO address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (minimum 2), giving the number of synchronizer flops on the incoming write pointer.
REQ-003 SHALL have parameter AE_THRESH, default 2, giving the almost-empty level threshold.
REQ-004 SHALL have port rd_clk, input, 1 bit: read-domain clock, the only clock in the block.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rd_req, input, 1 bit: consumer read request.
REQ-007 SHALL have port wr_ptr_gray, input, ADDR_W+1 bits: write pointer in Gray code, asynchronous to rd_clk.
REQ-008 SHALL have port rd_en, output, 1 bit: qualified read strobe to the RAM.
REQ-009 SHALL have port rd_addr, output, ADDR_W bits: RAM read address (low bits of the binary read pointer).
REQ-010 SHALL have port rd_ptr_gray, output, ADDR_W+1 bits: registered Gray read pointer, sent to the write domain.
REQ-011 SHALL have port empty, output, 1 bit: registered empty flag.
REQ-012 SHALL have port almost_empty, output, 1 bit: registered, set when level <= AE_THRESH.
REQ-013 SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected read.
REQ-014 SHALL have port rd_level, output, ADDR_W+1 bits: registered occupancy; present only under RD_LEVEL_EN.

Function
REQ-015 SHALL pass wr_ptr_gray through SYNC_STAGES flops (wq) and SHALL convert the last stage to binary (wbin).
REQ-016 SHALL drive rd_en = rd_req & ~empty combinationally.
REQ-017 SHALL keep an ADDR_W+1-bit binary read pointer rbin that increments by 1 on each rd_en cycle and wraps from 2^(ADDR_W+1)-1 to 0.
REQ-018 SHALL register rd_ptr_gray = rbin_next ^ (rbin_next >> 1), so that rd_ptr_gray changes by exactly one bit per increment.
REQ-019 SHALL register empty <= (gray(rbin_next) == wq_last), making empty reflect a read in the same cycle it happens.
REQ-020 SHALL compute level = (wbin - rbin_next) mod 2^(ADDR_W+1) and SHALL register almost_empty <= (level <= AE_THRESH).
REQ-021 SHALL register underflow <= rd_req & empty; it SHALL be high for exactly one cycle per rejected request, and rbin SHALL NOT change on that cycle.
REQ-022 After a write-pointer change that is stable before rd_clk edge N, empty SHALL deassert at edge N+SYNC_STAGES.
REQ-023 On the last read of the data (rbin_next == wbin), empty SHALL assert at that same edge, so no second read is issued.
REQ-024 A simultaneous read and a synchronized write-pointer update SHALL both be reflected in the same cycle's empty, almost_empty and level.

Reset
REQ-025 While rst_n is low, rbin, rd_ptr_gray, all sync flops, underflow and rd_level SHALL be 0, and empty and almost_empty SHALL be 1.
REQ-026 Reset asserted mid-operation SHALL clear state immediately (asynchronously); release SHALL take effect on the next rd_clk edge.

Configuration
REQ-027 Macro RD_LEVEL_EN SHALL control the level output: when it is defined, rd_level SHALL be registered <= level; when it is undefined, the rd_level port and its register SHALL be absent, and almost_empty SHALL still work.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the default ADDR_W and the bin2gray/gray2bin functions.
REQ-029 The synchronizer SHALL be a sub-module sync_nff (parameters WIDTH and STAGES, with the same clock and reset).

Verification
REQ-030 Reset: rst_n=0 -> empty=1, almost_empty=1, rd_ptr_gray=0, rd_addr=0, rd_en=0 even with rd_req=1.
REQ-031 Write 3 entries (wr_ptr_gray 0->3 Gray), then idle -> empty falls 3 edges later with default SYNC_STAGES; rd_level=3; almost_empty=0.
REQ-032 Drain: rd_req=1 for 4 cycles after REQ-031 -> rd_en high for 3 cycles, empty=1 after the 3rd read, underflow pulses once on the 4th cycle, rd_addr ends at 3.
REQ-033 Wrap: 40 write/read pairs at ADDR_W=4 -> rbin wraps from 31 to 0, rd_ptr_gray changes exactly one bit per increment, and there is no false empty or missed empty.
REQ-034 Simultaneous events: at level 1, a read and a new synchronized write in the same cycle -> empty stays 0 and rd_level stays 1.
REQ-035 Reset mid-stream: rst_n pulsed low at level 5 -> all outputs return to reset values with no rd_clk edge.
